// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction-memory read port between fetch (IF)
// and the data-load path (D). D has fixed priority. An anti-starvation
// counter hands the port to IF once it has been denied STARVE_LIMIT cycles.
// Read data comes back one cycle after the grant. Misaligned accesses are
// answered with an error and never strobe the memory.
module imem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic [31:0]      d_addr,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic             mem_en,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [2:0] {IDLE, RESP_IF, RESP_D, ERR_IF, ERR_D} resp_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  resp_t       resp, resp_nxt;
  logic [3:0]  starve_cnt;
  logic        if_win, d_win, any_gnt, aligned;
  logic [31:0] gnt_addr;

  // Winner selection and memory strobe; grants are suppressed during reset.
  always_comb begin
    if_win   = if_req && (!d_req || (starve_cnt == LIMIT));
    d_win    = d_req && !if_win;
    if_gnt   = if_win && rst_n;
    d_gnt    = d_win && rst_n;
    any_gnt  = if_gnt || d_gnt;
    gnt_addr = d_gnt ? d_addr : if_addr;
    aligned  = (gnt_addr[1:0] == 2'b00);
    mem_en   = any_gnt && aligned;
    mem_addr = mem_en ? gnt_addr : 32'h0;
  end

  // Response for next cycle: who owns it and whether it is an error.
  always_comb begin
    resp_nxt = IDLE;
    if (if_gnt)     resp_nxt = aligned ? RESP_IF : ERR_IF;
    else if (d_gnt) resp_nxt = aligned ? RESP_D  : ERR_D;
  end

  // Response state register; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp <= IDLE;
    else        resp <= resp_nxt;
  end

  // Response decode: data passes through only for aligned responses.
  always_comb begin
    if_rvalid = (resp == RESP_IF) || (resp == ERR_IF);
    if_err    = (resp == ERR_IF);
    if_rdata  = (resp == RESP_IF) ? mem_rdata : 32'h0;
    d_rvalid  = (resp == RESP_D) || (resp == ERR_D);
    d_err     = (resp == ERR_D);
    d_rdata   = (resp == RESP_D) ? mem_rdata : 32'h0;
  end

  // Count consecutive denied IF cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 starve_cnt <= 4'd0;
    else if (!if_req || if_gnt) starve_cnt <= 4'd0;
    else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
  end

  // Saturating count of cycles where both sides contend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (if_req && d_req && (conflict_cnt != {CNT_W{1'b1}}))
      conflict_cnt <= conflict_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vectors, a cycle-level reference model
// compared every cycle, and literal expectations for the key scenarios.
module tb_imem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0;
  logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_en;
  logic [31:0] if_rdata, d_rdata, mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [15:0] conflict_cnt;
  // second instance with a narrow counter to reach saturation quickly
  logic        s_if_gnt, s_if_rvalid, s_if_err, s_d_gnt, s_d_rvalid, s_d_err, s_mem_en;
  logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr;
  logic [3:0]  s_conflict_cnt;

  logic [31:0] mem [64];
  int total = 0, bad = 0;

  imem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt));

  imem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(s_if_gnt), .if_rvalid(s_if_rvalid),
    .if_rdata(s_if_rdata), .if_err(s_if_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid),
    .d_rdata(s_d_rdata), .d_err(s_d_err),
    .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_rdata(mem_rdata),
    .conflict_cnt(s_conflict_cnt));

  always #5 clk = ~clk;

  // instruction memory: word read, data one cycle after the strobe
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_starve;   // consecutive denied IF cycles
  int          m_pend;     // 0 none, 1 IF, 2 D
  logic        m_perr;
  logic [31:0] m_paddr;
  int          m_cnt, m_scnt;

  // 0 none, 1 IF, 2 D
  function automatic int winner();
    if (if_req && (!d_req || m_starve == LIMIT)) return 1;
    if (d_req) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_starve <= 0; m_pend <= 0; m_perr <= 1'b0; m_paddr <= '0;
      m_cnt <= 0; m_scnt <= 0;
    end else begin
      int w;
      logic [31:0] a;
      w = winner();
      a = (w == 1) ? if_addr : d_addr;
      m_pend  <= w;
      m_paddr <= a;
      m_perr  <= (w != 0) && (a[1:0] != 2'b00);
      if (if_req && w != 1) m_starve <= (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      else                  m_starve <= 0;
      if (if_req && d_req) begin
        m_cnt  <= (m_cnt  == 65535) ? m_cnt  : m_cnt + 1;
        m_scnt <= (m_scnt == 15)    ? m_scnt : m_scnt + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int w;
    logic [31:0] ga, er;
    logic e_en;
    w  = rst_n ? winner() : 0;
    ga = (w == 1) ? if_addr : d_addr;
    e_en = (w != 0) && (ga[1:0] == 2'b00);
    er = (m_pend != 0 && !m_perr) ? mem[m_paddr[7:2]] : 32'h0;
    chk("if_gnt",   {31'b0, if_gnt},   {31'b0, w == 1});
    chk("d_gnt",    {31'b0, d_gnt},    {31'b0, w == 2});
    chk("mem_en",   {31'b0, mem_en},   {31'b0, e_en});
    chk("mem_addr", mem_addr,          e_en ? ga : 32'h0);
    chk("if_rvalid",{31'b0, if_rvalid},{31'b0, m_pend == 1});
    chk("if_err",   {31'b0, if_err},   {31'b0, m_pend == 1 && m_perr});
    chk("if_rdata", if_rdata,          (m_pend == 1) ? er : 32'h0);
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, m_pend == 2});
    chk("d_err",    {31'b0, d_err},    {31'b0, m_pend == 2 && m_perr});
    chk("d_rdata",  d_rdata,           (m_pend == 2) ? er : 32'h0);
    chk("conflict_cnt", {16'b0, conflict_cnt}, 32'(m_cnt));
    chk("sat_conflict_cnt", {28'b0, s_conflict_cnt}, 32'(m_scnt));
  end

  // drive one cycle of inputs, return just after the falling edge
  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    @(negedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h05002083;
    mem[1]  = 32'h00100093;
    mem[2]  = 32'h00208113;
    mem[3]  = 32'h00310193;
    mem[4]  = 32'h11111111;
    mem[20] = 32'h00000005;
    mem[21] = 32'hDEADBEEF;
    mem[22] = 32'h22222222;

    // reset: requests present but nothing granted or counted
    @(negedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_addr = 32'h50;
    @(negedge clk); #1;
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst_d_gnt",  {31'b0, d_gnt},  32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_conflict", {16'b0, conflict_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;

    // IF alone, aligned
    cyc(1'b1, 32'h0, 1'b0, 32'h0);
    chk("t1_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h05002083);

    // contention: D wins, IF follows when D drops
    cyc(1'b1, 32'h4, 1'b1, 32'h50);
    chk("t2_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("t2_if_gnt", {31'b0, if_gnt}, 32'd0);
    cyc(1'b1, 32'h4, 1'b0, 32'h0);
    chk("t2_d_rdata", d_rdata, 32'h00000005);
    chk("t2_if_gnt2", {31'b0, if_gnt}, 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t2_if_rdata", if_rdata, 32'h00100093);

    // starvation bound: D x4, IF on 5th, D again on 6th
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h8, 1'b1, 32'h54);
      chk("t3_d_gnt", {31'b0, d_gnt}, 32'd1);
      chk("t3_if_gnt", {31'b0, if_gnt}, 32'd0);
    end
    cyc(1'b1, 32'h8, 1'b1, 32'h54);
    chk("t3_if_gnt5", {31'b0, if_gnt}, 32'd1);
    chk("t3_d_gnt5", {31'b0, d_gnt}, 32'd0);
    cyc(1'b1, 32'hC, 1'b1, 32'h54);
    chk("t3_d_gnt6", {31'b0, d_gnt}, 32'd1);
    chk("t3_if_rdata6", if_rdata, 32'h00208113);
    cyc(1'b1, 32'hC, 1'b0, 32'h0);
    chk("t3_d_rdata7", d_rdata, 32'hDEADBEEF);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);

    // misaligned D
    cyc(1'b0, 32'h0, 1'b1, 32'h52);
    chk("t4_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("t4_mem_en", {31'b0, mem_en}, 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t4_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("t4_d_err", {31'b0, d_err}, 32'd1);
    chk("t4_d_rdata", d_rdata, 32'h0);

    // reset the cycle after an IF grant: response dropped
    cyc(1'b1, 32'h8, 1'b0, 32'h0);
    chk("t5_if_gnt", {31'b0, if_gnt}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; if_req = 1'b0;
    @(negedge clk); #1;
    chk("t5_rst_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("t5_rst_rdata", if_rdata, 32'd0);
    chk("t5_rst_conflict", {16'b0, conflict_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t5_post_rvalid", {31'b0, if_rvalid}, 32'd0);

    // conflict counting and saturation of the narrow counter
    for (int k = 0; k < 10; k++) cyc(1'b1, 32'h10, 1'b1, 32'h58);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6_conflict10", {16'b0, conflict_cnt}, 32'd10);
    chk("t6_sat10", {28'b0, s_conflict_cnt}, 32'd10);
    for (int k = 0; k < 8; k++) cyc(1'b1, 32'h10, 1'b1, 32'h58);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6_conflict18", {16'b0, conflict_cnt}, 32'd18);
    chk("t6_sat15", {28'b0, s_conflict_cnt}, 32'd15);

    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
